// File: rtl/id_stage_pkg.sv
// Shared RV32IM decode definitions: opcodes, ALU/WB-select/immediate codes,
// ID/EX register layout and small ALU-code helpers.
package id_stage_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111
    } opcode_e;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_PASS_B = 5'd10,
        ALU_MUL    = 5'd11,
        ALU_MULH   = 5'd12,
        ALU_MULHSU = 5'd13,
        ALU_MULHU  = 5'd14,
        ALU_DIV    = 5'd15,
        ALU_DIVU   = 5'd16,
        ALU_REM    = 5'd17,
        ALU_REMU   = 5'd18
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'd0,
        WB_SEL_MEM = 2'd1,
        WB_SEL_PC4 = 2'd2
    } wb_sel_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        alu_op_e         alu_op;
        logic            op_a_pc;
        logic            op_b_imm;
        logic            reg_we;
        logic            mem_read;
        logic            mem_write;
        logic [2:0]      mem_size;
        wb_sel_e         wb_sel;
        logic            branch;
        logic            jump;
        logic            jalr;
        logic            illegal;
    } idex_t;

    // alt selects SUB/SRA (instr[30]); callers only raise it where legal.
    function automatic alu_op_e alu_base(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic alu_op_e alu_mext(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return ALU_MUL;
            3'b001:  return ALU_MULH;
            3'b010:  return ALU_MULHSU;
            3'b011:  return ALU_MULHU;
            3'b100:  return ALU_DIV;
            3'b101:  return ALU_DIVU;
            3'b110:  return ALU_REM;
            default: return ALU_REMU;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_reg_file.sv
// 32x32 register file, 2 combinational read ports, 1 write port, x0 reads zero.
// REGFILE_BYPASS_EN: same-cycle WB write is forwarded to the read ports.
module reg_file
    import id_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            we,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] data
);

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we && rd != '0) begin
            regs[rd] <= data;
        end
    end

    always_comb begin
        rs1_data = (rs1 == '0) ? '0 : regs[rs1];
        rs2_data = (rs2 == '0) ? '0 : regs[rs2];
`ifdef REGFILE_BYPASS_EN
        if (we && rd != '0 && rd == rs1) rs1_data = data;
        if (we && rd != '0 && rd == rs2) rs2_data = data;
`endif
    end

endmodule

// File: rtl/id_stage.sv
// RV32IM decode stage: register file, control decode, immediates, load-use
// hazard detection and the ID/EX pipeline register. Option: REGFILE_BYPASS_EN.
module id_stage
    import id_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_id,
    input  logic            flush_id,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] instr_in,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            load_use_stall,
    output logic            valid_ex,
    output logic [XLEN-1:0] pc_ex,
    output logic [XLEN-1:0] rs1_data_ex,
    output logic [XLEN-1:0] rs2_data_ex,
    output logic [XLEN-1:0] imm_ex,
    output logic [4:0]      rs1_ex,
    output logic [4:0]      rs2_ex,
    output logic [4:0]      rd_ex,
    output logic [4:0]      alu_op_ex,
    output logic            op_a_pc_ex,
    output logic            op_b_imm_ex,
    output logic            reg_we_ex,
    output logic            mem_read_ex,
    output logic            mem_write_ex,
    output logic [2:0]      mem_size_ex,
    output logic [1:0]      wb_sel_ex,
    output logic            branch_ex,
    output logic            jump_ex,
    output logic            jalr_ex,
    output logic            illegal_ex
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1_idx, rs2_idx, rd_idx;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            rs1_used, rs2_used, writes, bad;
    imm_type_e       imm_type;
    idex_t           dec, idex_q;

    assign opcode  = instr_in[6:0];
    assign funct3  = instr_in[14:12];
    assign funct7  = instr_in[31:25];
    assign rs1_idx = instr_in[19:15];
    assign rs2_idx = instr_in[24:20];
    assign rd_idx  = instr_in[11:7];

    reg_file u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .rs1      (rs1_idx),
        .rs2      (rs2_idx),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .we       (wb_we),
        .rd       (wb_rd),
        .data     (wb_data)
    );

    always_comb begin
        dec      = '0;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        writes   = 1'b0;
        bad      = 1'b0;
        imm_type = IMM_NONE;
        dec.alu_op = ALU_ADD;
        dec.wb_sel = WB_SEL_ALU;
        case (opcode)
            OPC_LUI: begin
                writes = 1'b1; imm_type = IMM_U; dec.op_b_imm = 1'b1; dec.alu_op = ALU_PASS_B;
            end
            OPC_AUIPC: begin
                writes = 1'b1; imm_type = IMM_U; dec.op_a_pc = 1'b1; dec.op_b_imm = 1'b1;
            end
            OPC_JAL: begin
                writes = 1'b1; imm_type = IMM_J; dec.op_a_pc = 1'b1; dec.op_b_imm = 1'b1;
                dec.jump = 1'b1; dec.wb_sel = WB_SEL_PC4;
            end
            OPC_JALR: begin
                bad = (funct3 != 3'b000);
                rs1_used = 1'b1; writes = 1'b1; imm_type = IMM_I; dec.op_b_imm = 1'b1;
                dec.jump = 1'b1; dec.jalr = 1'b1; dec.wb_sel = WB_SEL_PC4;
            end
            OPC_BRANCH: begin
                bad = (funct3 == 3'b010) || (funct3 == 3'b011);
                rs1_used = 1'b1; rs2_used = 1'b1; imm_type = IMM_B;
                dec.branch = 1'b1; dec.mem_size = funct3; dec.alu_op = ALU_SUB;
            end
            OPC_LOAD: begin
                bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
                rs1_used = 1'b1; writes = 1'b1; imm_type = IMM_I; dec.op_b_imm = 1'b1;
                dec.mem_read = 1'b1; dec.mem_size = funct3; dec.wb_sel = WB_SEL_MEM;
            end
            OPC_STORE: begin
                bad = (funct3[2] || funct3 == 3'b011);
                rs1_used = 1'b1; rs2_used = 1'b1; imm_type = IMM_S; dec.op_b_imm = 1'b1;
                dec.mem_write = 1'b1; dec.mem_size = funct3;
            end
            OPC_OP_IMM: begin
                // Shift-immediates carry funct7 in imm[11:5]; only SRAI may set bit 30.
                bad = (funct3 == 3'b001 && funct7 != 7'b0000000) ||
                      (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000);
                rs1_used = 1'b1; writes = 1'b1; imm_type = IMM_I; dec.op_b_imm = 1'b1;
                dec.alu_op = alu_base(funct3, funct3 == 3'b101 && funct7[5]);
            end
            OPC_OP: begin
                rs1_used = 1'b1; rs2_used = 1'b1; writes = 1'b1;
                if (funct7 == 7'b0000001)
                    dec.alu_op = alu_mext(funct3);
                else if (funct7 == 7'b0000000 ||
                         (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)))
                    dec.alu_op = alu_base(funct3, funct7[5]);
                else
                    bad = 1'b1;
            end
            default: bad = 1'b1;
        endcase

        if (bad) begin
            rs1_used      = 1'b0;
            rs2_used      = 1'b0;
            writes        = 1'b0;
            dec.mem_read  = 1'b0;
            dec.mem_write = 1'b0;
            dec.branch    = 1'b0;
            dec.jump      = 1'b0;
            dec.jalr      = 1'b0;
        end

        case (imm_type)
            IMM_I:   dec.imm = {{20{instr_in[31]}}, instr_in[31:20]};
            IMM_S:   dec.imm = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
            IMM_B:   dec.imm = {{19{instr_in[31]}}, instr_in[31], instr_in[7],
                                instr_in[30:25], instr_in[11:8], 1'b0};
            IMM_U:   dec.imm = {instr_in[31:12], 12'b0};
            IMM_J:   dec.imm = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12],
                                instr_in[20], instr_in[30:21], 1'b0};
            default: dec.imm = '0;
        endcase

        dec.valid    = 1'b1;
        dec.illegal  = bad;
        dec.pc       = pc_in;
        dec.rs1_data = rs1_data;
        dec.rs2_data = rs2_data;
        dec.rs1      = rs1_used ? rs1_idx : '0;
        dec.rs2      = rs2_used ? rs2_idx : '0;
        dec.rd       = writes ? rd_idx : '0;
        dec.reg_we   = writes && (rd_idx != '0);
    end

    assign load_use_stall = idex_q.mem_read && (idex_q.rd != '0) &&
                            ((idex_q.rd == rs1_idx && rs1_used) ||
                             (idex_q.rd == rs2_idx && rs2_used));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            idex_q <= '0;
        else if (flush_id)
            idex_q <= '0;
        else if (!stall_id)
            idex_q <= load_use_stall ? '0 : dec;
    end

    assign valid_ex     = idex_q.valid;
    assign pc_ex        = idex_q.pc;
    assign rs1_data_ex  = idex_q.rs1_data;
    assign rs2_data_ex  = idex_q.rs2_data;
    assign imm_ex       = idex_q.imm;
    assign rs1_ex       = idex_q.rs1;
    assign rs2_ex       = idex_q.rs2;
    assign rd_ex        = idex_q.rd;
    assign alu_op_ex    = idex_q.alu_op;
    assign op_a_pc_ex   = idex_q.op_a_pc;
    assign op_b_imm_ex  = idex_q.op_b_imm;
    assign reg_we_ex    = idex_q.reg_we;
    assign mem_read_ex  = idex_q.mem_read;
    assign mem_write_ex = idex_q.mem_write;
    assign mem_size_ex  = idex_q.mem_size;
    assign wb_sel_ex    = idex_q.wb_sel;
    assign branch_ex    = idex_q.branch;
    assign jump_ex      = idex_q.jump;
    assign jalr_ex      = idex_q.jalr;
    assign illegal_ex   = idex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage; covers REGFILE_BYPASS_EN either way.
module tb_id_stage;
    import id_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst, stall_id, flush_id, wb_we;
    logic [31:0] pc_in, instr_in, wb_data;
    logic [4:0]  wb_rd;
    logic        load_use_stall, valid_ex, op_a_pc_ex, op_b_imm_ex, reg_we_ex;
    logic        mem_read_ex, mem_write_ex, branch_ex, jump_ex, jalr_ex, illegal_ex;
    logic [31:0] pc_ex, rs1_data_ex, rs2_data_ex, imm_ex;
    logic [4:0]  rs1_ex, rs2_ex, rd_ex, alu_op_ex;
    logic [2:0]  mem_size_ex;
    logic [1:0]  wb_sel_ex;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .rst(rst), .stall_id(stall_id), .flush_id(flush_id),
        .pc_in(pc_in), .instr_in(instr_in),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .load_use_stall(load_use_stall), .valid_ex(valid_ex), .pc_ex(pc_ex),
        .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex), .imm_ex(imm_ex),
        .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex), .alu_op_ex(alu_op_ex),
        .op_a_pc_ex(op_a_pc_ex), .op_b_imm_ex(op_b_imm_ex), .reg_we_ex(reg_we_ex),
        .mem_read_ex(mem_read_ex), .mem_write_ex(mem_write_ex),
        .mem_size_ex(mem_size_ex), .wb_sel_ex(wb_sel_ex), .branch_ex(branch_ex),
        .jump_ex(jump_ex), .jalr_ex(jalr_ex), .illegal_ex(illegal_ex)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall_id = 1'b0; flush_id = 1'b0;
        pc_in = '0; instr_in = 32'h0000_0013;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        tick(); tick();
        chk("rst_valid", valid_ex, 0);
        chk("rst_pc", pc_ex, 0);
        chk("rst_rd", rd_ex, 0);
        chk("rst_lus", load_use_stall, 0);
        rst = 1'b0;

        // addi x1,x0,5 at pc 0x10
        pc_in = 32'h10; instr_in = 32'h0050_0093;
        tick();
        chk("addi_valid", valid_ex, 1);
        chk("addi_rd", rd_ex, 1);
        chk("addi_imm", imm_ex, 5);
        chk("addi_alu", alu_op_ex, ALU_ADD);
        chk("addi_opb", op_b_imm_ex, 1);
        chk("addi_we", reg_we_ex, 1);
        chk("addi_pc", pc_ex, 32'h10);

        // WB: x1=5, x2=DEADBEEF, then add x3,x1,x2 while WB targets x0
        instr_in = 32'h0000_0013; wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
        tick();
        wb_rd = 5'd2; wb_data = 32'hDEAD_BEEF;
        tick();
        wb_rd = 5'd0; wb_data = 32'h1234_5678; pc_in = 32'h14; instr_in = 32'h0020_81B3;
        tick();
        chk("add_rs1d", rs1_data_ex, 5);
        chk("add_rs2d", rs2_data_ex, 32'hDEAD_BEEF);
        chk("add_rd", rd_ex, 3);
        chk("add_opb", op_b_imm_ex, 0);
        wb_we = 1'b0; instr_in = 32'h0000_04B3;  // add x9,x0,x0
        tick();
        chk("x0_rs1d", rs1_data_ex, 0);
        chk("x0_rs2d", rs2_data_ex, 0);

        // load-use: lw x4,0(x1) then add x5,x4,x4
        instr_in = 32'h0000_A203;
        tick();
        chk("lw_memrd", mem_read_ex, 1);
        chk("lw_wbsel", wb_sel_ex, WB_SEL_MEM);
        chk("lw_size", mem_size_ex, 3'b010);
        instr_in = 32'h0042_02B3;
        #1;
        chk("lu_stall", load_use_stall, 1);
        tick();
        chk("lu_bubble", valid_ex, 0);
        chk("lu_cleared", load_use_stall, 0);
        tick();
        chk("lu_issue_v", valid_ex, 1);
        chk("lu_issue_rd", rd_ex, 5);
        chk("lu_issue_rs2", rs2_ex, 4);

        // rs2 field matches load rd but addi does not use rs2: no stall
        instr_in = 32'h0000_A203;
        tick();
        instr_in = 32'h0040_0393;  // addi x7,x0,4
        #1;
        chk("nouse_stall", load_use_stall, 0);
        tick();
        chk("nouse_imm", imm_ex, 4);
        chk("nouse_rd", rd_ex, 7);

        // flush + stall together -> bubble
        pc_in = 32'h20; instr_in = 32'h0050_0093; flush_id = 1'b1; stall_id = 1'b1;
        tick();
        chk("flush_valid", valid_ex, 0);
        chk("flush_we", reg_we_ex, 0);
        chk("flush_imm", imm_ex, 0);
        flush_id = 1'b0; stall_id = 1'b0;
        tick();
        chk("post_flush_pc", pc_ex, 32'h20);
        stall_id = 1'b1; pc_in = 32'h40; instr_in = 32'h0220_8333;
        tick();
        chk("stall_pc", pc_ex, 32'h20);
        chk("stall_imm", imm_ex, 5);
        chk("stall_alu", alu_op_ex, ALU_ADD);
        stall_id = 1'b0;

        // beq x1,x2,-8 / jal x1,+2048 / mul x6,x1,x2 / illegal opcode
        pc_in = 32'h44; instr_in = 32'hFE20_8CE3;
        tick();
        chk("beq_imm", imm_ex, 32'hFFFF_FFF8);
        chk("beq_br", branch_ex, 1);
        chk("beq_we", reg_we_ex, 0);
        pc_in = 32'h48; instr_in = 32'h0010_00EF;
        tick();
        chk("jal_imm", imm_ex, 32'h0000_0800);
        chk("jal_jump", jump_ex, 1);
        chk("jal_wbsel", wb_sel_ex, WB_SEL_PC4);
        chk("jal_opa", op_a_pc_ex, 1);
        pc_in = 32'h4C; instr_in = 32'h0220_8333;
        tick();
        chk("mul_alu", alu_op_ex, ALU_MUL);
        chk("mul_rd", rd_ex, 6);
        chk("mul_rs2d", rs2_data_ex, 32'hDEAD_BEEF);
        pc_in = 32'h50; instr_in = 32'h0000_00FF;
        tick();
        chk("ill_flag", illegal_ex, 1);
        chk("ill_valid", valid_ex, 1);
        chk("ill_we", reg_we_ex, 0);

        // asynchronous reset away from the clock edge
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", valid_ex, 0);
        chk("arst_pc", pc_ex, 0);
        chk("arst_ill", illegal_ex, 0);
        tick();
        rst = 1'b0; instr_in = 32'h0020_81B3;
        tick();
        chk("arst_x1", rs1_data_ex, 0);
        chk("arst_x2", rs2_data_ex, 0);

        // same-cycle WB x7=9 while decoding addi x8,x7,0
        wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'd9; instr_in = 32'h0003_8413;
        tick();
`ifdef REGFILE_BYPASS_EN
        chk("byp_rs1d", rs1_data_ex, 9);
`else
        chk("byp_rs1d", rs1_data_ex, 0);
`endif
        wb_we = 1'b0;
        tick();
        chk("wr_rs1d", rs1_data_ex, 9);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
